// File: rtl/datamemory_arbiter.sv
// Round-robin arbiter and sequencer sharing the single-ported datamemory between
// the CPU load/store port (A) and the loader port (B); one access per three cycles.
module datamemory_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic [1:0]  ReadA,
  input  logic [1:0]  ReadB,
  input  logic [5:0]  WriteA,
  input  logic [5:0]  WriteB,
  input  logic [31:0] AddrA,
  input  logic [31:0] AddrB,
  input  logic [31:0] WDataA,
  input  logic [31:0] WDataB,
  output logic        AckA,
  output logic        AckB,
  output logic        ErrA,
  output logic        ErrB,
  output logic [31:0] RDataA,
  output logic [31:0] RDataB,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [1:0]  MemRead,
  output logic [5:0]  MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic        PORT_A  = 1'b0;
  localparam logic        PORT_B  = 1'b1;

  // A command is rejected unless it is exactly one legal read or one legal store in range.
  function automatic logic cmd_error(input logic [1:0] rd, input logic [5:0] wr,
                                     input logic [31:0] addr);
    logic wr_legal;
    wr_legal = (wr == 6'd0) || (wr == 6'd40) || (wr == 6'd41) || (wr == 6'd43);
    return ((rd != 2'd0) && (wr != 6'd0)) || ((rd == 2'd0) && (wr == 6'd0)) ||
           !wr_legal || (addr >= DEPTH_W);
  endfunction

  state_t      state_q;
  logic        last_q;
  logic        cmd_port_q;
  logic        ack_a_q;
  logic        ack_b_q;
  logic        err_a_q;
  logic        err_b_q;
  logic [31:0] rdata_a_q;
  logic [31:0] rdata_b_q;
  // The memory-facing half of the command register doubles as the strobe outputs.
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_read_q;
  logic [5:0]  mem_write_q;

  logic        cmd_port_d;
  logic [1:0]  cmd_read_d;
  logic [5:0]  cmd_write_d;
  logic [31:0] cmd_addr_d;
  logic [31:0] cmd_wdata_d;
  logic        cmd_err_d;

  // Winner selection: on a tie the port not granted last time wins.
  always_comb begin
    cmd_port_d = ReqB && (!ReqA || (last_q == PORT_A));
    if (cmd_port_d == PORT_B) begin
      cmd_read_d  = ReadB;
      cmd_write_d = WriteB;
      cmd_addr_d  = AddrB;
      cmd_wdata_d = WDataB;
    end else begin
      cmd_read_d  = ReadA;
      cmd_write_d = WriteA;
      cmd_addr_d  = AddrA;
      cmd_wdata_d = WDataA;
    end
    cmd_err_d = cmd_error(cmd_read_d, cmd_write_d, cmd_addr_d);
  end

  // Sequencer FSM with all outputs registered; strobes default to zero every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_B;
      cmd_port_q  <= PORT_A;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      rdata_a_q   <= 32'd0;
      rdata_b_q   <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 2'd0;
      mem_write_q <= 6'd0;
    end else begin
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_read_q  <= 2'd0;
      mem_write_q <= 6'd0;
      case (state_q)
        IDLE: begin
          if (ReqA || ReqB) begin
            cmd_port_q <= cmd_port_d;
            if (cmd_err_d) begin
              ack_a_q <= (cmd_port_d == PORT_A);
              ack_b_q <= (cmd_port_d == PORT_B);
              err_a_q <= (cmd_port_d == PORT_A);
              err_b_q <= (cmd_port_d == PORT_B);
              state_q <= RESP;
            end else begin
              mem_addr_q  <= cmd_addr_d;
              mem_wdata_q <= cmd_wdata_d;
              mem_read_q  <= cmd_read_d;
              mem_write_q <= cmd_write_d;
              state_q     <= ACCESS;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (mem_read_q != 2'd0) begin
            if (cmd_port_q == PORT_B) begin
              rdata_b_q <= MemReadData;
            end else begin
              rdata_a_q <= MemReadData;
            end
          end
          ack_a_q <= (cmd_port_q == PORT_A);
          ack_b_q <= (cmd_port_q == PORT_B);
          state_q <= RESP;
        end
        RESP: begin
          last_q  <= cmd_port_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign AckA         = ack_a_q;
  assign AckB         = ack_b_q;
  assign ErrA         = err_a_q;
  assign ErrB         = err_b_q;
  assign RDataA       = rdata_a_q;
  assign RDataB       = rdata_b_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;

endmodule
